// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - aluop codes, FSM encoding and op-classification helpers for the MEM stage
package mem_access_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
    localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
    localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
    localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
    localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
    localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
    localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
    localparam logic [7:0] EXE_SW_OP  = 8'b11101011;
    localparam logic [7:0] EXE_LL_OP  = 8'b11110000;
    localparam logic [7:0] EXE_SC_OP  = 8'b11111000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } mem_state_t;

    function automatic logic is_load_op(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_LL_OP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        case (op)
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SC_OP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] lo);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP:        return lo[0];
            EXE_LW_OP, EXE_SW_OP, EXE_LL_OP, EXE_SC_OP: return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - req/ack data bus between the MEM stage and memory
interface mem_access_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
        input  dbus_rdata, dbus_ack
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
        output dbus_rdata, dbus_ack
    );
endinterface

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - big-endian byte/half select and sign/zero extension of bus read data
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = 8'h00;
        sel_half = 16'h0000;
        data     = rdata;
        // Byte address 00 lives in bits 31:24 on this big-endian bus.
        case (addr_lo)
            2'b00:   sel_byte = rdata[31:24];
            2'b01:   sel_byte = rdata[23:16];
            2'b10:   sel_byte = rdata[15:8];
            default: sel_byte = rdata[7:0];
        endcase
        sel_half = addr_lo[1] ? rdata[15:0] : rdata[31:16];
        case (aluop)
            EXE_LB_OP:  data = {{24{sel_byte[7]}}, sel_byte};
            EXE_LBU_OP: data = {24'h000000, sel_byte};
            EXE_LH_OP:  data = {{16{sel_half[15]}}, sel_half};
            EXE_LHU_OP: data = {16'h0000, sel_half};
            default:    data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MIPS MEM stage: bus sequencing, stall request, load formatting, LL/SC link bit
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    output logic [4:0]  out_wd,
    output logic        out_wreg,
    output logic [31:0] out_wdata,
    output logic        stallreq,
    output logic [1:0]  align_err,
    mem_access_if.master dbus
);

    mem_state_t  state, next_state;
    logic        llbit;
    logic [31:0] result;
    logic        start_bus;

    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [7:0]  bus_op;
    logic [1:0]  bus_lo;

    logic        is_load, is_store, is_mem, misaligned;
    logic [3:0]  req_sel;
    logic [31:0] req_wdata;
    logic [31:0] load_data;

    logic unused_stall;
    assign unused_stall = &{1'b0, stall[5], stall[3:0]};

    assign is_load    = is_load_op(mem_aluop);
    assign is_store   = is_store_op(mem_aluop);
    assign is_mem     = is_load | is_store;
    assign misaligned = is_misaligned(mem_aluop, mem_mem_addr[1:0]);

    always_comb begin
        req_sel   = 4'b1111;
        req_wdata = 32'h0;
        case (mem_aluop)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: req_sel = 4'b1000 >> mem_mem_addr[1:0];
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: req_sel = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
            default:                          req_sel = 4'b1111;
        endcase
        case (mem_aluop)
            EXE_SB_OP:            req_wdata = {4{mem_reg2[7:0]}};
            EXE_SH_OP:            req_wdata = {2{mem_reg2[15:0]}};
            EXE_SW_OP, EXE_SC_OP: req_wdata = mem_reg2;
            default:              req_wdata = 32'h0;
        endcase
    end

    mem_load_align u_load_align (
        .aluop   (bus_op),
        .addr_lo (bus_lo),
        .rdata   (dbus.dbus_rdata),
        .data    (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start_bus  = 1'b0;
        out_wd     = mem_wd;
        out_wreg   = mem_wreg;
        out_wdata  = mem_wdata;
        stallreq   = 1'b0;
        align_err  = 2'b00;
        case (state)
            ST_IDLE: begin
                if (flush) begin
                    out_wd    = 5'd0;
                    out_wreg  = 1'b0;
                    out_wdata = 32'h0;
                end else if (misaligned) begin
                    align_err = is_load ? 2'b01 : 2'b10;
                    out_wreg  = 1'b0;
                end else if (mem_aluop == EXE_SC_OP && !llbit) begin
                    out_wreg  = 1'b1;
                    out_wdata = 32'h0;
                end else if (is_mem) begin
                    stallreq   = 1'b1;
                    start_bus  = 1'b1;
                    next_state = ST_BUS;
                end
            end
            ST_BUS: begin
                stallreq = !flush;
                out_wreg = 1'b0;
                if (flush) begin
                    next_state = dbus.dbus_ack ? ST_IDLE : ST_ABORT;
                end else if (dbus.dbus_ack) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                out_wdata = result;
                if (flush) begin
                    out_wd     = 5'd0;
                    out_wreg   = 1'b0;
                    out_wdata  = 32'h0;
                    next_state = ST_IDLE;
                end else if (!stall[4]) begin
                    next_state = ST_IDLE;
                end
            end
            ST_ABORT: begin
                // The flushed transfer must still drain; a new memory op waits behind it.
                out_wreg = 1'b0;
                stallreq = is_mem && !flush;
                if (dbus.dbus_ack) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if (rst) begin
            out_wd    = 5'd0;
            out_wreg  = 1'b0;
            out_wdata = 32'h0;
            stallreq  = 1'b0;
            align_err = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            llbit     <= 1'b0;
            result    <= 32'h0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_sel   <= 4'h0;
            bus_wdata <= 32'h0;
            bus_op    <= 8'h00;
            bus_lo    <= 2'b00;
        end else begin
            if (start_bus) begin
                bus_we    <= is_store;
                bus_addr  <= {mem_mem_addr[31:2], 2'b00};
                bus_sel   <= req_sel;
                bus_wdata <= req_wdata;
                bus_op    <= mem_aluop;
                bus_lo    <= mem_mem_addr[1:0];
            end
            if (state == ST_BUS && dbus.dbus_ack && !flush) begin
                if (bus_op == EXE_SC_OP) begin
                    result <= 32'h1;
                end else if (bus_we) begin
                    result <= 32'h0;
                end else begin
                    result <= load_data;
                end
                if (bus_op == EXE_LL_OP) begin
                    llbit <= 1'b1;
                end else if (bus_op == EXE_SC_OP) begin
                    llbit <= 1'b0;
                end
            end
            if (flush) begin
                llbit <= 1'b0;
            end
        end
    end

    assign dbus.dbus_req   = (state == ST_BUS) || (state == ST_ABORT);
    assign dbus.dbus_we    = bus_we;
    assign dbus.dbus_addr  = bus_addr;
    assign dbus.dbus_sel   = bus_sel;
    assign dbus.dbus_wdata = bus_wdata;

endmodule
